// File: rtl/program_loader.sv
// program_loader: length-prefixed byte-stream loader that writes instruction memory, then releases the core.
// Optional PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the last instruction.
module program_loader #(
   parameter int WORDSIZE         = 64,
   parameter int INSTRUCTION_SIZE = 32,
   parameter int ADDR_WIDTH       = 10,
   parameter int MAX_WORDS        = 1024
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        byte_valid,
   input  logic [7:0]                  byte_data,
   output logic                        byte_ready,
   input  logic                        reload,
   output logic                        imem_we,
   output logic [ADDR_WIDTH-1:0]       imem_addr,
   output logic [INSTRUCTION_SIZE-1:0] imem_wdata,
   output logic                        cpu_reset_n,
   output logic [WORDSIZE-1:0]         pc_start,
   output logic                        done,
   output logic                        error
);
   typedef enum logic [2:0] {HDR_LO, HDR_HI, CHECK, DATA, WRITE, CSUM, RUN, ERROR} state_t;
   state_t                      state;
   logic [15:0]                 count;
   logic [ADDR_WIDTH-1:0]       word_cnt;
   logic [1:0]                  byte_idx;
   logic [INSTRUCTION_SIZE-9:0] instr;
   logic                        accept, last;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]                  csum;
`endif
   assign accept   = byte_valid && byte_ready;
   assign last     = 32'(word_cnt) + 32'd1 == 32'(count);
   assign pc_start = '0;
   // instr holds the three earlier bytes; the fourth is merged straight into imem_wdata
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state       <= HDR_LO;
         byte_ready  <= 1'b0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         cpu_reset_n <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         count       <= '0;
         word_cnt    <= '0;
         byte_idx    <= '0;
         instr       <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum        <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
         case (state)
            HDR_LO: begin
               byte_ready <= 1'b1;
               if (accept) begin
                  count[7:0] <= byte_data;
                  state      <= HDR_HI;
               end
            end
            HDR_HI: if (accept) begin
               count[15:8] <= byte_data;
               byte_ready  <= 1'b0;
               state       <= CHECK;
            end
            CHECK: if (count == 16'd0 || 32'(count) > 32'(MAX_WORDS)) begin
               error <= 1'b1;
               state <= ERROR;
            end else begin
               word_cnt   <= '0;
               byte_idx   <= '0;
               byte_ready <= 1'b1;
               state      <= DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum       <= '0;
`endif
            end
            DATA: if (accept) begin
               instr    <= {byte_data, instr[INSTRUCTION_SIZE-9:8]};
               byte_idx <= byte_idx + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum     <= csum ^ byte_data;
`endif
               if (byte_idx == 2'd3) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= word_cnt;
                  imem_wdata <= {byte_data, instr};
                  byte_ready <= 1'b0;
                  state      <= WRITE;
               end
            end
            WRITE: begin
               word_cnt <= word_cnt + 1'b1;
               if (!last) begin
                  byte_ready <= 1'b1;
                  state      <= DATA;
               end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  byte_ready <= 1'b1;
                  state      <= CSUM;
`else
                  cpu_reset_n <= 1'b1;
                  done        <= 1'b1;
                  state       <= RUN;
`endif
               end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CSUM: if (accept) begin
               byte_ready  <= 1'b0;
               cpu_reset_n <= byte_data == csum;
               done        <= byte_data == csum;
               error       <= byte_data != csum;
               state       <= byte_data == csum ? RUN : ERROR;
            end
`endif
            RUN, ERROR: if (reload) begin
               cpu_reset_n <= 1'b0;
               done        <= 1'b0;
               error       <= 1'b0;
               state       <= HDR_LO;
            end
            default: state <= HDR_LO;
         endcase
      end
endmodule
